// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and default parameter values for the PLL controller.
// max3() sizes the shared sequencing counter from the parameter set.
package pll_ctrl_pkg;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_FILTER  = 64;
  localparam int DEF_LOCK_TIMEOUT = 4096;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_STAGGER      = 8;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_FILTER    = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } pll_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_ctrl_sync.sv
// Two-flop synchronizer for a single asynchronous level; adds two cycles of latency.
// Both flops clear to 0 on reset so a stale lock is never seen after reset.
module pll_ctrl_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_ctrl.sv
// PLL power-up/lock sequencer with lock filtering and staggered channel reset release.
// Define PLL_CTRL_WATCHDOG_EN to enable the lock timeout, retry counting and the FAIL state.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int STAGGER      = DEF_STAGGER
) (
  input  logic                           clkin,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           pll_lock,
  output logic                           pll_reset,
  output logic                           pll_pwd,
  output logic [NUM_CH-1:0]              ch_rst_n,
  output logic                           locked,
  output logic                           err,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int REL_LAST = (NUM_CH - 1) * STAGGER;
  localparam int CNT_MAX  = max3(RST_CYCLES, LOCK_FILTER, REL_LAST);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  if (NUM_CH < 1 || NUM_CH > 7 || RST_CYCLES < 1 || LOCK_FILTER < 1 ||
      LOCK_TIMEOUT < 1 || MAX_RETRY < 1 || STAGGER < 1) begin : g_param_check
    $error("pll_ctrl: parameter out of range");
  end

  pll_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_sat;
  logic              lock_s;
  logic              timeout;
  logic              retry_ok;

  logic              pwd_q, pwd_d;
  logic              prst_q, prst_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              locked_q, locked_d;

  pll_ctrl_sync u_lock_sync (
    .clk_i   (clkin),
    .rst_n_i (rst_n),
    .d_i     (pll_lock),
    .q_o     (lock_s)
  );

  // One counter serves the reset pulse, the lock filter and the release stagger.
  assign cnt_sat = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
        ST_RESET: begin
          if (cnt_q >= CNT_W'(RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
        ST_WAIT_LOCK: begin
          if (timeout) begin
            state_d = retry_ok ? ST_RESET : ST_FAIL;
            cnt_d   = '0;
          end else if (lock_s) begin
            state_d = ST_FILTER;
            cnt_d   = '0;
          end
        end
        ST_FILTER: begin
          // Timeout is checked first so a lock that only settles late still retries.
          if (timeout) begin
            state_d = retry_ok ? ST_RESET : ST_FAIL;
            cnt_d   = '0;
          end else if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q >= CNT_W'(LOCK_FILTER - 1)) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
        ST_RELEASE: begin
          if (!lock_s) begin
            state_d = ST_RESET;
            cnt_d   = '0;
          end else if (cnt_q >= CNT_W'(REL_LAST)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RESET;
            cnt_d   = '0;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so each register lines up with its state.
  always_comb begin
    pwd_d    = (state_d == ST_OFF);
    prst_d   = (state_d == ST_OFF) || (state_d == ST_RESET) || (state_d == ST_FAIL);
    locked_d = (state_d == ST_RUN);
    ch_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_d[i] = (state_d == ST_RUN) ||
                ((state_d == ST_RELEASE) && (cnt_d >= CNT_W'(i * STAGGER)));
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      pwd_q    <= 1'b1;
      prst_q   <= 1'b1;
      ch_q     <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwd_q    <= pwd_d;
      prst_q   <= prst_d;
      ch_q     <= ch_d;
      locked_q <= locked_d;
    end
  end

  assign pll_pwd   = pwd_q;
  assign pll_reset = prst_q;
  assign ch_rst_n  = ch_q;
  assign locked    = locked_q;

`ifdef PLL_CTRL_WATCHDOG_EN
  localparam int RC_W = $clog2(MAX_RETRY + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

  logic [TO_W-1:0] to_q, to_d;
  logic [RC_W-1:0] retry_q, retry_d;
  logic            err_q;

  // The timeout window spans WAIT_LOCK and FILTER together; only a new RESET restarts it.
  assign timeout  = ((state_q == ST_WAIT_LOCK) || (state_q == ST_FILTER)) &&
                    (to_q >= TO_W'(LOCK_TIMEOUT - 1));
  assign retry_ok = (retry_q < RC_W'(MAX_RETRY));

  always_comb begin
    to_d = to_q;
    if ((state_d == ST_RESET) && (state_q != ST_RESET)) begin
      to_d = '0;
    end else if (((state_q == ST_WAIT_LOCK) || (state_q == ST_FILTER)) &&
                 (to_q != TO_W'(LOCK_TIMEOUT))) begin
      to_d = to_q + 1'b1;
    end
    retry_d = retry_q;
    if (!en || (state_d == ST_RUN)) begin
      retry_d = '0;
    end else if (timeout && (state_d == ST_RESET)) begin
      retry_d = retry_q + 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      to_q    <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      to_q    <= to_d;
      retry_q <= retry_d;
      err_q   <= (state_d == ST_FAIL);
    end
  end

  assign err       = err_q;
  assign retry_cnt = retry_q;
`else
  assign timeout   = 1'b0;
  assign retry_ok  = 1'b1;
  assign err       = 1'b0;
  assign retry_cnt = '0;
`endif

  a_locked_all_ch: assert property (@(posedge clkin) disable iff (!rst_n)
    locked |-> (&ch_rst_n));
  a_err_safe: assert property (@(posedge clkin) disable iff (!rst_n)
    err |-> (pll_reset && !pll_pwd && (ch_rst_n == '0) && !locked));

endmodule

// File: tb/tb_pll_ctrl.sv
// Scoreboard bench for pll_ctrl: u_a uses default parameters, u_b a short lock timeout.
module tb_pll_ctrl;

  logic       clkin = 1'b0;
  logic       rst_n;
  logic       en_a, lock_a, en_b, lock_b;
  logic       pll_reset_a, pll_pwd_a, locked_a, err_a;
  logic       pll_reset_b, pll_pwd_b, locked_b, err_b;
  logic [3:0] ch_a, ch_b;
  logic [1:0] retry_a, retry_b;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int t, t0, t1;

  typedef struct {
    string tag;
    int    exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  pll_ctrl u_a (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .en        (en_a),
    .pll_lock  (lock_a),
    .pll_reset (pll_reset_a),
    .pll_pwd   (pll_pwd_a),
    .ch_rst_n  (ch_a),
    .locked    (locked_a),
    .err       (err_a),
    .retry_cnt (retry_a)
  );

  pll_ctrl #(.LOCK_TIMEOUT(50), .MAX_RETRY(3)) u_b (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .en        (en_b),
    .pll_lock  (lock_b),
    .pll_reset (pll_reset_b),
    .pll_pwd   (pll_pwd_b),
    .ch_rst_n  (ch_b),
    .locked    (locked_b),
    .err       (err_b),
    .retry_cnt (retry_b)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int act);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, act, e.exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0, 1, 2, 3: return ch_a[sel];
      4:          return locked_a;
      5:          return pll_reset_a;
      6:          return pll_pwd_a;
      7:          return pll_reset_b;
      default:    return 1'bx;
    endcase
  endfunction

  // Waits at negedges until the selected output equals val; returns the cycle stamp.
  task automatic wait_sig(input string tag, input int sel, input logic val,
                          input int maxc, output int at);
    int n = 0;
    while (sig(sel) !== val && n < maxc) begin
      @(negedge clkin);
      n++;
    end
    if (sig(sel) !== val) begin
      chk(tag, int'(sig(sel)), int'(val));
      at = -1;
    end else begin
      at = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=0", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en_a = 1'b0; lock_a = 1'b0; en_b = 1'b0; lock_b = 1'b0;
    repeat (3) @(negedge clkin);

    chk("rst_pwd", pll_pwd_a, 1);
    chk("rst_prst", pll_reset_a, 1);
    chk("rst_ch", int'(ch_a), 0);
    chk("rst_locked", locked_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_retry", int'(retry_a), 0);
    chk("rst_b_err", err_b, 0);

    rst_n = 1'b1;
    @(negedge clkin);

    // Power-up: pwd drops on the first edge, reset held for 16 cycles in RESET.
    en_a = 1'b1; t0 = cyc;
    sb_push("pwd_fall", 1);
    sb_push("prst_fall", 17);
    wait_sig("w_pwd_fall", 6, 1'b0, 40, t); sb_pop(t - t0);
    wait_sig("w_prst_fall", 5, 1'b0, 40, t); sb_pop(t - t0);

    // Lock appears 100 cycles later: 2 sync + 64 filter, then 8-cycle stagger.
    repeat (100) @(negedge clkin);
    lock_a = 1'b1; t0 = cyc;
    for (int i = 0; i < 4; i++) sb_push($sformatf("rel_ch%0d", i), 67 + 8 * i);
    sb_push("run_locked", 67 + 25);
    for (int i = 0; i < 4; i++) begin
      wait_sig($sformatf("w_ch%0d", i), i, 1'b1, 200, t); sb_pop(t - t0);
    end
    wait_sig("w_locked", 4, 1'b1, 50, t); sb_pop(t - t0);
    chk("run_ch", int'(ch_a), 15);
    chk("run_prst", pll_reset_a, 0);
    chk("run_pwd", pll_pwd_a, 0);
    chk("run_retry", int'(retry_a), 0);

    // Loss of lock in RUN: outputs drop 3 cycles after the raw drop, one 16-cycle reset.
    lock_a = 1'b0; t0 = cyc;
    sb_push("loss_ch", 3);
    sb_push("loss_locked", 3);
    sb_push("loss_prst_rise", 3);
    sb_push("loss_prst_w", 16);
    wait_sig("w_loss_ch", 0, 1'b0, 10, t); sb_pop(t - t0);
    chk("loss_ch_all", int'(ch_a), 0);
    wait_sig("w_loss_locked", 4, 1'b0, 10, t); sb_pop(t - t0);
    wait_sig("w_loss_prst", 5, 1'b1, 10, t); sb_pop(t - t0);
    t1 = t;
    wait_sig("w_loss_prst_fall", 5, 1'b0, 40, t); sb_pop(t - t1);
    chk("loss_retry", int'(retry_a), 0);

    // One-cycle glitch at filter count 40 restarts the full 64-cycle filter.
    lock_a = 1'b1; t0 = cyc;
    sb_push("glitch_rel", 41 + 67);
    repeat (40) @(negedge clkin);
    lock_a = 1'b0;
    @(negedge clkin);
    lock_a = 1'b1;
    wait_sig("w_glitch_rel", 0, 1'b1, 200, t); sb_pop(t - t0);

    // en dropped after ch0 and ch1 release: OFF on the next edge.
    wait_sig("w_partial", 1, 1'b1, 20, t);
    chk("partial_ch", int'(ch_a), 3);
    en_a = 1'b0;
    sb_push("off_ch", 0);
    sb_push("off_pwd", 1);
    sb_push("off_prst", 1);
    @(negedge clkin);
    sb_pop(int'(ch_a));
    sb_pop(pll_pwd_a);
    sb_pop(pll_reset_a);

    // Restart with lock already present, then assert rst_n between edges in RUN.
    en_a = 1'b1; t0 = cyc;
    sb_push("rerun_locked", 107);
    wait_sig("w_rerun", 4, 1'b1, 300, t); sb_pop(t - t0);
    @(posedge clkin);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwd", pll_pwd_a, 1);
    chk("arst_prst", pll_reset_a, 1);
    chk("arst_ch", int'(ch_a), 0);
    chk("arst_locked", locked_a, 0);
    chk("arst_retry", int'(retry_a), 0);
    en_a = 1'b0; lock_a = 1'b0;
    @(negedge clkin);
    rst_n = 1'b1;
    @(negedge clkin);

    // No lock ever on u_b.
    en_b = 1'b1; t0 = cyc;
    sb_push("b_prst_fall", 17);
    wait_sig("w_b_prst_fall", 7, 1'b0, 40, t); sb_pop(t - t0);
`ifdef PLL_CTRL_WATCHDOG_EN
    for (int r = 1; r <= 3; r++) begin
      t1 = t;
      sb_push($sformatf("b_wait_w%0d", r), 50);
      sb_push($sformatf("b_retry%0d", r), r);
      sb_push($sformatf("b_rst_w%0d", r), 16);
      wait_sig("w_b_rise", 7, 1'b1, 100, t); sb_pop(t - t1);
      sb_pop(int'(retry_b));
      t1 = t;
      wait_sig("w_b_fall", 7, 1'b0, 40, t); sb_pop(t - t1);
    end
    t1 = t;
    sb_push("b_fail_wait_w", 50);
    sb_push("b_fail_err", 1);
    sb_push("b_fail_retry", 3);
    sb_push("b_fail_pwd", 0);
    wait_sig("w_b_fail", 7, 1'b1, 100, t); sb_pop(t - t1);
    sb_pop(err_b);
    sb_pop(int'(retry_b));
    sb_pop(pll_pwd_b);
    repeat (30) @(negedge clkin);
    chk("b_fail_hold_err", err_b, 1);
    chk("b_fail_hold_prst", pll_reset_b, 1);
    chk("b_fail_hold_ch", int'(ch_b), 0);
    en_b = 1'b0;
    @(negedge clkin);
    chk("b_off_err", err_b, 0);
    chk("b_off_retry", int'(retry_b), 0);
    chk("b_off_pwd", pll_pwd_b, 1);
`else
    repeat (300) @(negedge clkin);
    chk("b_nowd_prst", pll_reset_b, 0);
    chk("b_nowd_err", err_b, 0);
    chk("b_nowd_retry", int'(retry_b), 0);
    chk("b_nowd_pwd", pll_pwd_b, 0);
    en_b = 1'b0;
    @(negedge clkin);
    chk("b_off_pwd", pll_pwd_b, 1);
`endif

    chk("sb_left", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
